id_stage_hazard: RTL and testbench
==================================

// Module: id_stage_hazard
// PURPOSE
// - Parametrised decode stage for the pipelined ARMv8 (LEGv8) core, between IF/ID and EX.
// - Holds the register file, decodes control, resolves CBZ/CBNZ/B/BL/BR in ID and detects load-use and branch-operand hazards.
// - Owns the ID/EX pipeline register and inserts bubbles on stall.
// PARAMETERS
// - XLEN      64  datapath/register width (32 or 64)
// - PC_W      64  PC width
// - LINK_REG  30  destination register written by BL
// - ZERO_REG  31  register that always reads 0; writes to it are discarded
// PORTS
// - clock            in   1     single clock; all state updates on posedge
// - reset            in   1     synchronous, active-high
// - if_valid         in   1     IF/ID holds a real instruction
// - instruction      in   32    IF/ID instruction
// - pc               in   PC_W  IF/ID PC of instruction
// - wb_regwrite      in   1     MEM/WB write enable
// - wb_reg           in   5     MEM/WB destination
// - wb_data          in   XLEN  MEM/WB write data
// - mem_regwrite     in   1     EX/MEM writes a register
// - mem_memread      in   1     EX/MEM is a load
// - mem_reg          in   5     EX/MEM destination
// - mem_fwd_data     in   XLEN  EX/MEM ALU result (forwarded to branch compare)
// - stall            out  1     hold PC and IF/ID this cycle
// - flush_if         out  1     branch taken: squash IF/ID next cycle
// - branch_target    out  PC_W  redirect PC, valid when flush_if=1
// - id_ex_valid      out  1     ID/EX holds a real instruction
// - id_ex_illegal    out  1     ID/EX captured an undecodable opcode
// - id_ex_ctrl       out  8     {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Link,Uncond}
// - id_ex_aluop      out  2     00 add, 01 pass-B/compare, 10 R-type
// - id_ex_rdata1/2   out  XLEN  operand values (Rn; Rm or Rt)
// - id_ex_imm        out  XLEN  sign-extended immediate
// - id_ex_rn/rm/rd   out  5     register indices for EX forwarding
// - id_ex_pc         out  PC_W  PC of captured instruction
// BEHAVIOUR
// - Reset: all ID/EX outputs 0, all registers 0; stall/flush_if low during reset.
// - Decode: LDUR, STUR, ADD, SUB, AND, ORR, CBZ, CBNZ, B, BL, BR; anything else is illegal.
// - Immediates: D[20:12], CB[23:5], B/BL[25:0], each sign-extended to XLEN.
// - Second read port selects Rt[4:0] (Reg2Loc=1: STUR/CBZ/CBNZ), else Rm[20:16].
// - Reads are combinational; ZERO_REG reads 0.
// - RF write on posedge when wb_regwrite && wb_reg!=ZERO_REG.
// - Load-use: id_ex_valid & MemRead & rd!=ZERO_REG & rd matches a used source -> stall=1 for 1 cycle.
// - Branch operand (CBZ/CBNZ Rt, BR Rn) = X:
//   - id_ex RegWrite & rd==X -> stall.
//   - mem_regwrite & mem_memread & mem_reg==X -> stall.
//   - mem_regwrite & !mem_memread & mem_reg==X -> compare mem_fwd_data; no stall.
// - Stall: ID/EX loads a bubble (valid=0, ctrl=0); no branch resolution; flush_if=0.
// - Taken when if_valid & !stall & (B | BL | BR | CBZ&op==0 | CBNZ&op!=0):
//   - flush_if=1, same cycle, combinational.
//   - Target = pc+(imm<<2); BR uses operand value truncated/zero-extended to PC_W.
//   - PC arithmetic wraps modulo 2^PC_W.
// - BL: ID/EX captures RegWrite=1, Link=1, rd=LINK_REG; EX writes id_ex_pc+4.
// - Illegal: ID/EX valid=0, illegal=1 for one cycle; no hazard or branch.
// - if_valid=0: bubble captured; stall=0.
// - ID/EX latency: 1 cycle (captured on posedge after decode).
// - Reset asserted mid-stall: next cycle bubble, stall=0, registers cleared.
// CONFIGURATION
// - RF_BYPASS_EN defined: read of wb_reg in the same cycle as a write returns wb_data (write-through).
// - RF_BYPASS_EN undefined: read returns the old value.
//   - Hazard unit adds a 1-cycle stall when a used source == wb_reg with wb_regwrite=1 and wb_reg!=ZERO_REG.
// TESTING
// - X1=5 via WB; next cycle ADD X2,X1,X1 -> id_ex_rdata1=id_ex_rdata2=5, valid=1.
//   - Bypass on: 0 stalls; bypass off: 1 stall.
// - LDUR X3,[X1,#8] then ADD X4,X3,X3 -> stall=1 one cycle.
//   - Bubble (valid=0) in ID/EX; ADD captured next cycle with rn=rm=3.
// - CBZ X5 at pc=0x100, imm19=4, X5=0 -> flush_if=1, branch_target=0x110.
//   - X5=7 -> flush_if=0.
// - ADD X6 in EX/MEM (mem_fwd_data=0), CBNZ X6 in ID -> no stall, not taken.
//   - Same with mem_memread=1 -> stall 1 cycle.
// - BL imm26=-1 at pc=0x200 -> branch_target=0x1FC, flush_if=1.
//   - ID/EX: RegWrite=1, Link=1, rd=30, id_ex_pc=0x200.
// - Write X31=0xFF then read X31 -> 0; opcode 0x7FF -> id_ex_illegal=1 one cycle.
//   - reset during stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_stage_hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_hazard_if
// Brief    : IF/ID, EX/MEM and MEM/WB inputs plus ID/EX outputs of the decode stage
// Revision : 1.0 - initial release
// ============================================================================
interface id_stage_hazard_if #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
);
    logic            if_valid;
    logic [31:0]     instruction;
    logic [PC_W-1:0] pc;
    logic            wb_regwrite;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;
    logic            mem_regwrite;
    logic            mem_memread;
    logic [4:0]      mem_reg;
    logic [XLEN-1:0] mem_fwd_data;
    logic            stall;
    logic            flush_if;
    logic [PC_W-1:0] branch_target;
    logic            id_ex_valid;
    logic            id_ex_illegal;
    logic [7:0]      id_ex_ctrl;
    logic [1:0]      id_ex_aluop;
    logic [XLEN-1:0] id_ex_rdata1;
    logic [XLEN-1:0] id_ex_rdata2;
    logic [XLEN-1:0] id_ex_imm;
    logic [4:0]      id_ex_rn;
    logic [4:0]      id_ex_rm;
    logic [4:0]      id_ex_rd;
    logic [PC_W-1:0] id_ex_pc;

    modport master (
        output if_valid, instruction, pc, wb_regwrite, wb_reg, wb_data,
               mem_regwrite, mem_memread, mem_reg, mem_fwd_data,
        input  stall, flush_if, branch_target, id_ex_valid, id_ex_illegal,
               id_ex_ctrl, id_ex_aluop, id_ex_rdata1, id_ex_rdata2, id_ex_imm,
               id_ex_rn, id_ex_rm, id_ex_rd, id_ex_pc
    );

    modport slave (
        input  if_valid, instruction, pc, wb_regwrite, wb_reg, wb_data,
               mem_regwrite, mem_memread, mem_reg, mem_fwd_data,
        output stall, flush_if, branch_target, id_ex_valid, id_ex_illegal,
               id_ex_ctrl, id_ex_aluop, id_ex_rdata1, id_ex_rdata2, id_ex_imm,
               id_ex_rn, id_ex_rm, id_ex_rd, id_ex_pc
    );
endinterface
`default_nettype wire

// File: rtl/id_stage_hazard.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_hazard
// Brief    : LEGv8 decode stage: register file, control decode, ID-stage branch
//            resolution, load-use/branch-operand hazards and the ID/EX register.
//            Define RF_BYPASS_EN for write-through register file reads.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_hazard #(
    parameter int XLEN     = 64,
    parameter int PC_W     = 64,
    parameter int LINK_REG = 30,
    parameter int ZERO_REG = 31
) (
    input  logic             clock,
    input  logic             reset,
    id_stage_hazard_if.slave bus
);
    localparam logic [4:0] c_link_reg = 5'(LINK_REG);
    localparam logic [4:0] c_zero_reg = 5'(ZERO_REG);

    logic [XLEN-1:0] r_regs [32];
    logic            r_valid, r_illegal;
    logic [7:0]      r_ctrl;
    logic [1:0]      r_aluop;
    logic [XLEN-1:0] r_rdata1, r_rdata2, r_imm;
    logic [4:0]      r_rn, r_rm, r_rd;
    logic [PC_W-1:0] r_pc;

    logic [10:0] w_op;
    logic [4:0]  w_rn, w_rm, w_rt, w_rs2, w_bx;
    logic w_ldur, w_stur, w_add, w_sub, w_and, w_orr, w_cbz, w_cbnz, w_b, w_bl, w_br;
    logic w_rtype, w_is_cb, w_legal, w_active, w_use_rn, w_use_rs2, w_bop;
    logic w_ld_use, w_br_idex, w_br_memld, w_fwd, w_wb_haz, w_stall, w_capture;
    logic w_bzero, w_take;
    logic [7:0]      w_ctrl;
    logic [1:0]      w_aluop;
    logic [XLEN-1:0] w_imm, w_rdata1, w_rdata2, w_bval;
    logic [PC_W-1:0] w_off;
    logic            w_unused_bits;

    assign w_op   = bus.instruction[31:21];
    assign w_rn   = bus.instruction[9:5];
    assign w_rm   = bus.instruction[20:16];
    assign w_rt   = bus.instruction[4:0];
    assign w_ldur = (w_op == 11'h7C2);
    assign w_stur = (w_op == 11'h7C0);
    assign w_add  = (w_op == 11'h458);
    assign w_sub  = (w_op == 11'h658);
    assign w_and  = (w_op == 11'h450);
    assign w_orr  = (w_op == 11'h550);
    assign w_br   = (w_op == 11'h6B0);
    assign w_cbz  = (w_op[10:3] == 8'hB4);
    assign w_cbnz = (w_op[10:3] == 8'hB5);
    assign w_b    = (w_op[10:5] == 6'h05);
    assign w_bl   = (w_op[10:5] == 6'h25);
    assign w_unused_bits = ^bus.instruction[11:10];

    assign w_rtype   = w_add | w_sub | w_and | w_orr;
    assign w_is_cb   = w_cbz | w_cbnz;
    assign w_legal   = w_rtype | w_ldur | w_stur | w_is_cb | w_b | w_bl | w_br;
    assign w_active  = bus.if_valid & w_legal & ~reset;
    assign w_rs2     = (w_stur | w_is_cb) ? w_rt : w_rm;
    assign w_use_rn  = w_rtype | w_ldur | w_stur | w_br;
    assign w_use_rs2 = w_rtype | w_stur | w_is_cb;
    assign w_bop     = w_is_cb | w_br;
    assign w_bx      = w_br ? w_rn : w_rt;

    always_comb begin
        w_ctrl  = 8'h00;
        w_aluop = 2'b00;
        w_imm   = '0;
        w_off   = '0;
        if (w_rtype) begin
            w_ctrl  = 8'h10;
            w_aluop = 2'b10;
        end
        if (w_ldur)      w_ctrl = 8'h78;
        if (w_stur)      w_ctrl = 8'hC4;
        if (w_b | w_br)  w_ctrl = 8'h01;
        if (w_bl)        w_ctrl = 8'h13;
        if (w_is_cb) begin
            w_ctrl  = 8'h80;
            w_aluop = 2'b01;
            w_imm   = {{(XLEN-19){bus.instruction[23]}}, bus.instruction[23:5]};
            w_off   = {{(PC_W-19){bus.instruction[23]}}, bus.instruction[23:5]};
        end
        if (w_ldur | w_stur)
            w_imm = {{(XLEN-9){bus.instruction[20]}}, bus.instruction[20:12]};
        if (w_b | w_bl) begin
            w_imm = {{(XLEN-26){bus.instruction[25]}}, bus.instruction[25:0]};
            w_off = {{(PC_W-26){bus.instruction[25]}}, bus.instruction[25:0]};
        end
    end

    // Register reads: ZERO_REG forced to 0 last so it overrides any bypass.
    always_comb begin
        w_rdata1 = r_regs[w_rn];
        w_rdata2 = r_regs[w_rs2];
`ifdef RF_BYPASS_EN
        if (bus.wb_regwrite && bus.wb_reg == w_rn)  w_rdata1 = bus.wb_data;
        if (bus.wb_regwrite && bus.wb_reg == w_rs2) w_rdata2 = bus.wb_data;
`endif
        if (w_rn == c_zero_reg)  w_rdata1 = '0;
        if (w_rs2 == c_zero_reg) w_rdata2 = '0;
    end

    assign w_ld_use = r_valid & r_ctrl[3] & (r_rd != c_zero_reg) &
                      ((w_use_rn & (r_rd == w_rn)) | (w_use_rs2 & (r_rd == w_rs2)));
    assign w_br_idex  = w_bop & r_ctrl[4] & (r_rd == w_bx) & (w_bx != c_zero_reg);
    assign w_br_memld = w_bop & bus.mem_regwrite & bus.mem_memread &
                        (bus.mem_reg == w_bx) & (w_bx != c_zero_reg);
    assign w_fwd      = w_bop & bus.mem_regwrite & ~bus.mem_memread &
                        (bus.mem_reg == w_bx) & (w_bx != c_zero_reg);
`ifdef RF_BYPASS_EN
    assign w_wb_haz = 1'b0;
`else
    // Without write-through the RF value is stale until the write lands.
    assign w_wb_haz = bus.wb_regwrite & (bus.wb_reg != c_zero_reg) &
                      ((w_use_rn & (bus.wb_reg == w_rn)) | (w_use_rs2 & (bus.wb_reg == w_rs2)));
`endif

    assign w_stall   = w_active & (w_ld_use | w_br_idex | w_br_memld | w_wb_haz);
    assign w_capture = w_active & ~w_stall;
    assign w_bval    = w_fwd ? bus.mem_fwd_data : (w_br ? w_rdata1 : w_rdata2);
    assign w_bzero   = (w_bval == '0);
    assign w_take    = w_capture & (w_b | w_bl | w_br | (w_cbz & w_bzero) | (w_cbnz & ~w_bzero));

    assign bus.stall         = w_stall;
    assign bus.flush_if      = w_take;
    assign bus.branch_target = w_br ? PC_W'(w_bval) : bus.pc + {w_off[PC_W-3:0], 2'b00};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (bus.wb_regwrite && bus.wb_reg != c_zero_reg) begin
            r_regs[bus.wb_reg] <= bus.wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !w_capture) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_aluop  <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_rd     <= '0;
            r_pc     <= '0;
        end else begin
            r_valid  <= 1'b1;
            r_ctrl   <= w_ctrl;
            r_aluop  <= w_aluop;
            r_rdata1 <= w_rdata1;
            r_rdata2 <= w_rdata2;
            r_imm    <= w_imm;
            r_rn     <= w_rn;
            r_rm     <= w_rs2;
            r_rd     <= w_bl ? c_link_reg : w_rt;
            r_pc     <= bus.pc;
        end
        r_illegal <= ~reset & bus.if_valid & ~w_legal;
    end

    assign bus.id_ex_valid   = r_valid;
    assign bus.id_ex_illegal = r_illegal;
    assign bus.id_ex_ctrl    = r_ctrl;
    assign bus.id_ex_aluop   = r_aluop;
    assign bus.id_ex_rdata1  = r_rdata1;
    assign bus.id_ex_rdata2  = r_rdata2;
    assign bus.id_ex_imm     = r_imm;
    assign bus.id_ex_rn      = r_rn;
    assign bus.id_ex_rm      = r_rm;
    assign bus.id_ex_rd      = r_rd;
    assign bus.id_ex_pc      = r_pc;
endmodule
`default_nettype wire

// File: tb/tb_id_stage_hazard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_hazard
// Brief    : directed vectors for id_stage_hazard with hand-computed expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_hazard;
    localparam int XLEN = 64;
    localparam int PC_W = 64;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    id_stage_hazard_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    id_stage_hazard #(.XLEN(XLEN), .PC_W(PC_W), .LINK_REG(30), .ZERO_REG(31)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm,
                                           input logic [4:0] rt);
        return {op, imm, rt};
    endfunction

    function automatic logic [31:0] enc_br(input logic [4:0] rn);
        return {11'h6B0, 5'h1F, 6'd0, rn, 5'd0};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.if_valid = 0; bus.instruction = 0; bus.pc = 0;
        bus.wb_regwrite = 0; bus.wb_reg = 0; bus.wb_data = 0;
        bus.mem_regwrite = 0; bus.mem_memread = 0; bus.mem_reg = 0; bus.mem_fwd_data = 0;
        tick(); tick();
        check_eq("rst_stall", bus.stall, 0);
        check_eq("rst_flush", bus.flush_if, 0);
        check_eq("rst_valid", bus.id_ex_valid, 0);
        check_eq("rst_ctrl", bus.id_ex_ctrl, 0);
        check_eq("rst_illegal", bus.id_ex_illegal, 0);
        reset = 1'b0;

        // X1=5 written while ADD X2,X1,X1 sits in ID
        bus.if_valid = 1; bus.pc = 64'h10; bus.instruction = enc_r(11'h458, 5'd1, 5'd1, 5'd2);
        bus.wb_regwrite = 1; bus.wb_reg = 5'd1; bus.wb_data = 64'd5;
        #1;
`ifdef RF_BYPASS_EN
        check_eq("wb_stall", bus.stall, 0);
`else
        check_eq("wb_stall", bus.stall, 1);
`endif
        tick();
        bus.wb_regwrite = 0;
`ifndef RF_BYPASS_EN
        check_eq("wb_bubble", bus.id_ex_valid, 0);
        #1;
        check_eq("wb_unstall", bus.stall, 0);
        tick();
`endif
        check_eq("add_valid", bus.id_ex_valid, 1);
        check_eq("add_rdata1", bus.id_ex_rdata1, 5);
        check_eq("add_rdata2", bus.id_ex_rdata2, 5);
        check_eq("add_rd", bus.id_ex_rd, 2);
        check_eq("add_ctrl", bus.id_ex_ctrl, 8'h10);
        check_eq("add_aluop", bus.id_ex_aluop, 2'b10);

        // Load-use
        bus.pc = 64'h14; bus.instruction = enc_d(11'h7C2, 9'd8, 5'd1, 5'd3);
        #1;
        check_eq("ldur_nostall", bus.stall, 0);
        tick();
        check_eq("ldur_ctrl", bus.id_ex_ctrl, 8'h78);
        check_eq("ldur_imm", bus.id_ex_imm, 8);
        check_eq("ldur_rdata1", bus.id_ex_rdata1, 5);
        check_eq("ldur_rd", bus.id_ex_rd, 3);
        bus.pc = 64'h18; bus.instruction = enc_r(11'h458, 5'd3, 5'd3, 5'd4);
        #1;
        check_eq("lu_stall", bus.stall, 1);
        check_eq("lu_flush", bus.flush_if, 0);
        tick();
        check_eq("lu_bubble_valid", bus.id_ex_valid, 0);
        check_eq("lu_bubble_ctrl", bus.id_ex_ctrl, 0);
        #1;
        check_eq("lu_release", bus.stall, 0);
        tick();
        check_eq("lu_add_valid", bus.id_ex_valid, 1);
        check_eq("lu_add_rn", bus.id_ex_rn, 3);
        check_eq("lu_add_rm", bus.id_ex_rm, 3);
        check_eq("lu_add_rd", bus.id_ex_rd, 4);

        // CBZ X5 with X5=0
        bus.pc = 64'h100; bus.instruction = enc_cb(8'hB4, 19'd4, 5'd5);
        #1;
        check_eq("cbz_flush", bus.flush_if, 1);
        check_eq("cbz_target", bus.branch_target, 64'h110);
        check_eq("cbz_stall", bus.stall, 0);
        tick();
        check_eq("cbz_ctrl", bus.id_ex_ctrl, 8'h80);
        check_eq("cbz_aluop", bus.id_ex_aluop, 2'b01);
        check_eq("cbz_imm", bus.id_ex_imm, 4);
        bus.if_valid = 0;
        bus.wb_regwrite = 1; bus.wb_reg = 5'd5; bus.wb_data = 64'd7;
        tick();
        bus.wb_reg = 5'd6; bus.wb_data = 64'd9;
        tick();
        bus.wb_regwrite = 0;
        bus.if_valid = 1;
        #1;
        check_eq("cbz_nt_flush", bus.flush_if, 0);
        check_eq("cbz_nt_stall", bus.stall, 0);
        bus.instruction = enc_cb(8'hB5, 19'h7FFFE, 5'd5);
        #1;
        check_eq("cbnz_neg_flush", bus.flush_if, 1);
        check_eq("cbnz_neg_target", bus.branch_target, 64'hF8);
        tick();

        // CBNZ X6 with ADD X6 in EX/MEM forwarding 0
        bus.mem_regwrite = 1; bus.mem_memread = 0; bus.mem_reg = 5'd6; bus.mem_fwd_data = 0;
        bus.pc = 64'h300; bus.instruction = enc_cb(8'hB5, 19'd1, 5'd6);
        #1;
        check_eq("fwd_stall", bus.stall, 0);
        check_eq("fwd_flush", bus.flush_if, 0);
        bus.mem_memread = 1;
        #1;
        check_eq("memld_stall", bus.stall, 1);
        check_eq("memld_flush", bus.flush_if, 0);
        tick();
        check_eq("memld_bubble", bus.id_ex_valid, 0);
        bus.mem_regwrite = 0; bus.mem_memread = 0;
        #1;
        check_eq("memld_release", bus.stall, 0);
        check_eq("cbnz_rf_flush", bus.flush_if, 1);
        check_eq("cbnz_rf_target", bus.branch_target, 64'h304);
        tick();

        // BL, then BR hazards and wrap
        bus.pc = 64'h200; bus.instruction = {6'h25, 26'h3FFFFFF};
        #1;
        check_eq("bl_flush", bus.flush_if, 1);
        check_eq("bl_target", bus.branch_target, 64'h1FC);
        tick();
        check_eq("bl_ctrl", bus.id_ex_ctrl, 8'h13);
        check_eq("bl_rd", bus.id_ex_rd, 30);
        check_eq("bl_pc", bus.id_ex_pc, 64'h200);
        check_eq("bl_valid", bus.id_ex_valid, 1);
        bus.pc = 64'h204; bus.instruction = enc_br(5'd30);
        #1;
        check_eq("br_haz_stall", bus.stall, 1);
        check_eq("br_haz_flush", bus.flush_if, 0);
        tick();
        check_eq("br_haz_bubble", bus.id_ex_valid, 0);
        #1;
        check_eq("br_release", bus.flush_if, 1);
        tick();
        bus.pc = 64'h208; bus.instruction = enc_br(5'd1);
        #1;
        check_eq("br_flush", bus.flush_if, 1);
        check_eq("br_target", bus.branch_target, 5);
        tick();
        bus.pc = 64'h0; bus.instruction = {6'h05, 26'h3FFFFFF};
        #1;
        check_eq("b_wrap_target", bus.branch_target, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("b_wrap_flush", bus.flush_if, 1);
        tick();

        // Zero register and illegal opcode
        bus.if_valid = 0;
        bus.wb_regwrite = 1; bus.wb_reg = 5'd31; bus.wb_data = 64'hFF;
        tick();
        bus.wb_regwrite = 0;
        bus.if_valid = 1; bus.instruction = enc_r(11'h458, 5'd31, 5'd31, 5'd7);
        #1;
        check_eq("x31_stall", bus.stall, 0);
        tick();
        check_eq("x31_rdata1", bus.id_ex_rdata1, 0);
        check_eq("x31_rdata2", bus.id_ex_rdata2, 0);
        bus.instruction = 32'hFFE0_0000;
        #1;
        check_eq("ill_stall", bus.stall, 0);
        check_eq("ill_flush", bus.flush_if, 0);
        tick();
        check_eq("ill_flag", bus.id_ex_illegal, 1);
        check_eq("ill_valid", bus.id_ex_valid, 0);
        bus.if_valid = 0;
        tick();
        check_eq("ill_clear", bus.id_ex_illegal, 0);

        // Reset during a load-use stall
        bus.if_valid = 1; bus.pc = 64'h400; bus.instruction = enc_d(11'h7C2, 9'd0, 5'd1, 5'd8);
        tick();
        bus.pc = 64'h404; bus.instruction = enc_r(11'h458, 5'd8, 5'd8, 5'd9);
        #1;
        check_eq("rs_stall", bus.stall, 1);
        reset = 1'b1;
        #1;
        check_eq("rs_stall_low", bus.stall, 0);
        tick();
        check_eq("rs_valid", bus.id_ex_valid, 0);
        check_eq("rs_ctrl", bus.id_ex_ctrl, 0);
        check_eq("rs_pc", bus.id_ex_pc, 0);
        check_eq("rs_rd", bus.id_ex_rd, 0);
        reset = 1'b0;
        bus.instruction = enc_r(11'h458, 5'd1, 5'd1, 5'd10);
        #1;
        check_eq("rs_after_stall", bus.stall, 0);
        tick();
        check_eq("rs_rf_cleared", bus.id_ex_rdata1, 0);
        check_eq("rs_after_valid", bus.id_ex_valid, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
